axis_sample_fifo: RTL and testbench

Synchronous AXI4-Stream FIFO that sits directly upstream of the AXI4-Lite stream reader. It buffers a free-running sample stream, for example ADC data, so that slow processor polling over AXI4-Lite does not lose words. It also exports its fill level, so software can read the count first and then drain exactly that many words. The output stage is first-word-fall-through: `m_axis_tdata` is valid whenever `m_axis_tvalid` is high.

---
 rtl/axis_sample_fifo.sv | 132 +++++++++++++
 tb/tb_axis_sample_fifo.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_sample_fifo.sv
// axis_sample_fifo: synchronous AXI4-Stream sample FIFO with a first-word-fall-through
// output register and an exported fill level.
// Build option: define AXIS_SAMPLE_FIFO_DROP_EN to discard words offered while full
// and raise a sticky overflow flag. Undefined, the FIFO backpressures via s_axis_tready.
module axis_sample_fifo #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int ADDR_WIDTH       = 10
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [ADDR_WIDTH:0]         fifo_count,
    output logic                        overflow
);
    localparam int                  DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [AXIS_TDATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]         ram_cnt_q, ram_cnt_d;   // words held in the RAM only
    logic [ADDR_WIDTH:0]         cnt_q, cnt_d;           // RAM words + output register word
    logic                        ovld_q, ovld_d;
    logic [AXIS_TDATA_WIDTH-1:0] odata_q, odata_d;
    logic                        full, push, pop, load_ram, bypass, take;

    assign full = (cnt_q == DEPTH_C);

`ifdef AXIS_SAMPLE_FIFO_DROP_EN
    logic ovf_q;

    // Input is never stalled; a word offered while full is dropped even if a pop
    // happens on the same edge.
    assign s_axis_tready = 1'b1;
    assign push          = s_axis_tvalid && !full;
    assign overflow      = ovf_q;

    // Sticky loss flag, cleared only by reset.
    always_ff @(posedge aclk) begin
        if (areset) ovf_q <= 1'b0;
        else if (s_axis_tvalid && full) ovf_q <= 1'b1;
    end
`else
    logic rdy_q;

    // Ready is registered from the next count so it never depends on m_axis_tready
    // combinationally; it equals !full for the current count.
    assign s_axis_tready = rdy_q;
    assign push          = s_axis_tvalid && rdy_q;
    assign overflow      = 1'b0;

    // Registered not-full flag.
    always_ff @(posedge aclk) begin
        if (areset) rdy_q <= 1'b1;
        else        rdy_q <= (cnt_d != DEPTH_C);
    end
`endif

    assign pop = ovld_q && m_axis_tready;
    // Refill the head from RAM when it is empty or being popped.
    assign load_ram = (ram_cnt_q != '0) && (!ovld_q || pop);
    // Head popped with the RAM empty and a push arriving: the pushed word becomes the
    // head directly so the stream has no bubble. It is still written to RAM and both
    // pointers advance, keeping the RAM count at zero.
    assign bypass = pop && (ram_cnt_q == '0) && push;
    assign take   = load_ram || bypass;

    // Next-state for pointers, counts and the output register.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        ram_cnt_d = ram_cnt_q;
        cnt_d     = cnt_q;
        ovld_d    = ovld_q;
        odata_d   = odata_q;
        if (push) wptr_d = wptr_q + PTR_ONE;
        if (take) rptr_d = rptr_q + PTR_ONE;
        case ({push, take})
            2'b10:   ram_cnt_d = ram_cnt_q + CNT_ONE;
            2'b01:   ram_cnt_d = ram_cnt_q - CNT_ONE;
            default: ram_cnt_d = ram_cnt_q;
        endcase
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
        if (load_ram) begin
            odata_d = mem_q[rptr_q];
            ovld_d  = 1'b1;
        end else if (bypass) begin
            odata_d = s_axis_tdata;
            ovld_d  = 1'b1;
        end else if (pop) begin
            ovld_d  = 1'b0;
        end
    end

    // Storage write; contents are not reset and become unreachable after a reset.
    always_ff @(posedge aclk) begin
        if (push) mem_q[wptr_q] <= s_axis_tdata;
    end

    // State registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            ram_cnt_q <= '0;
            cnt_q     <= '0;
            ovld_q    <= 1'b0;
            odata_q   <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ram_cnt_q <= ram_cnt_d;
            cnt_q     <= cnt_d;
            ovld_q    <= ovld_d;
            odata_q   <= odata_d;
        end
    end

    assign m_axis_tdata  = odata_q;
    assign m_axis_tvalid = ovld_q;
    assign fifo_count    = cnt_q;
endmodule

// File: tb/tb_axis_sample_fifo.sv
// Directed bench for axis_sample_fifo (default parameters, DEPTH = 1024).
module tb_axis_sample_fifo;
    localparam int W     = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    logic          aclk = 1'b0;
    logic          areset;
    logic [W-1:0]  s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [AW:0]   fifo_count;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    axis_sample_fifo #(.AXIS_TDATA_WIDTH(W), .ADDR_WIDTH(AW)) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        areset        = 1'b1;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        step();
        areset = 1'b0;
    endtask

    // Push n words base, base+1, ... honouring s_axis_tready.
    task automatic fill(input int n, input logic [W-1:0] base);
        int  i = 0;
        int  guard = 0;
        logic acc;
        s_axis_tvalid = 1'b1;
        while (i < n && guard < 5000) begin
            s_axis_tdata = base + W'(i);
            @(negedge aclk);
            acc = s_axis_tready;
            step();
            if (acc) i++;
            guard++;
        end
        s_axis_tvalid = 1'b0;
        chk("fill_words", 64'(i), 64'(n));
    endtask

    // Pop n words and expect base, base+1, ...
    task automatic drain(input int n, input logic [W-1:0] base, input string tag);
        int bad = 0;
        m_axis_tready = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge aclk);
            if (!m_axis_tvalid || m_axis_tdata !== base + W'(k)) bad++;
            step();
        end
        m_axis_tready = 1'b0;
        chk(tag, 64'(bad), 64'd0);
    endtask

    initial begin
        logic [W-1:0] q[$];
        logic [W-1:0] exp_w;
        int bad, popped, cyc;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        areset        = 1'b1;
        step();
        step();
        areset = 1'b0;

        // Reset state
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tdata",  64'(m_axis_tdata),  64'd0);
        chk("rst_count",  64'(fifo_count),    64'd0);
        chk("rst_ovf",    64'(overflow),      64'd0);
        chk("rst_tready", 64'(s_axis_tready), 64'd1);

        // Three words, consumer stalled; check two-edge latency
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'h11; step();
        chk("lat_cnt1",   64'(fifo_count),    64'd1);
        chk("lat_vld0",   64'(m_axis_tvalid), 64'd0);
        s_axis_tdata = 32'h22; step();
        chk("lat_vld1",   64'(m_axis_tvalid), 64'd1);
        chk("lat_head",   64'(m_axis_tdata),  64'h11);
        s_axis_tdata = 32'h33; step();
        s_axis_tvalid = 1'b0;
        chk("three_cnt",  64'(fifo_count),    64'd3);
        step();
        chk("hold_head",  64'(m_axis_tdata),  64'h11);
        m_axis_tready = 1'b1;
        chk("pop_11", 64'(m_axis_tdata), 64'h11); step();
        chk("pop_22", 64'(m_axis_tdata), 64'h22); step();
        chk("pop_33", 64'(m_axis_tdata), 64'h33); step();
        m_axis_tready = 1'b0;
        chk("empty_vld", 64'(m_axis_tvalid), 64'd0);
        chk("empty_cnt", 64'(fifo_count),    64'd0);

        // Full boundary
        fill(DEPTH, 32'h0);
        chk("full_cnt", 64'(fifo_count), 64'(DEPTH));
`ifdef AXIS_SAMPLE_FIFO_DROP_EN
        for (int k = 0; k < 5; k++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = 32'hDEAD0000 + W'(k); step();
        end
        s_axis_tvalid = 1'b0;
        chk("drop_cnt",    64'(fifo_count),    64'(DEPTH));
        chk("drop_ovf",    64'(overflow),      64'd1);
        chk("drop_tready", 64'(s_axis_tready), 64'd1);
        drain(DEPTH, 32'h0, "drop_drain");
        chk("drop_empty",  64'(m_axis_tvalid), 64'd0);
        chk("drop_sticky", 64'(overflow),      64'd1);
        do_reset();
        chk("drop_rst_ovf", 64'(overflow), 64'd0);
`else
        chk("full_tready", 64'(s_axis_tready), 64'd0);
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'hBAD; step();
        s_axis_tvalid = 1'b0;
        chk("full_hold_cnt", 64'(fifo_count), 64'(DEPTH));
        chk("full_no_ovf",   64'(overflow),   64'd0);
        chk("full_head",     64'(m_axis_tdata), 64'd0);
        m_axis_tready = 1'b1; step(); m_axis_tready = 1'b0;
        chk("pop1_tready", 64'(s_axis_tready), 64'd1);
        chk("pop1_cnt",    64'(fifo_count),    64'(DEPTH-1));
        chk("pop1_head",   64'(m_axis_tdata),  64'd1);
        drain(DEPTH-1, 32'h1, "full_drain");
        chk("full_empty",  64'(fifo_count), 64'd0);
`endif

        // Random stream through the wrapping pointers against a scoreboard
        do_reset();
        q.delete();
        bad = 0; popped = 0; cyc = 0;
        while (popped < 3000 && cyc < 30000) begin
            s_axis_tvalid = 1'($urandom_range(0, 1));
            s_axis_tdata  = $urandom;
            m_axis_tready = 1'($urandom_range(0, 1));
            @(negedge aclk);
            if (m_axis_tvalid && m_axis_tready) begin
                if (q.size() == 0) bad++;
                else begin
                    exp_w = q.pop_front();
                    if (m_axis_tdata !== exp_w) bad++;
                end
                popped++;
            end
            if (s_axis_tvalid && s_axis_tready) q.push_back(s_axis_tdata);
            step();
            if (int'(fifo_count) != q.size()) bad++;
            cyc++;
        end
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        chk("stream_popped", 64'(popped), 64'd3000);
        chk("stream_bad",    64'(bad),    64'd0);

        // Steady state at one word: push+pop every cycle, no bubble
        do_reset();
        q.delete();
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'h100; step();
        s_axis_tvalid = 1'b0; step();
        q.push_back(32'h100);
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = 32'h200 + W'(k); m_axis_tready = 1'b1;
            @(negedge aclk);
            if (!m_axis_tvalid) bad++;
            exp_w = q.pop_front();
            if (m_axis_tdata !== exp_w) bad++;
            q.push_back(s_axis_tdata);
            step();
            if (fifo_count != 11'd1) bad++;
        end
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        chk("steady_bad",  64'(bad),          64'd0);
        chk("steady_head", 64'(m_axis_tdata), 64'h263);

        // Reset mid-operation, then no stale data
        do_reset();
        fill(500, 32'h5000);
        chk("mid_cnt", 64'(fifo_count), 64'd500);
        do_reset();
        chk("mid_rst_cnt", 64'(fifo_count),    64'd0);
        chk("mid_rst_vld", 64'(m_axis_tvalid), 64'd0);
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'hA5; step();
        s_axis_tvalid = 1'b0;
        chk("a5_cnt",  64'(fifo_count),    64'd1);
        chk("a5_vld0", 64'(m_axis_tvalid), 64'd0);
        step();
        chk("a5_vld1", 64'(m_axis_tvalid), 64'd1);
        chk("a5_head", 64'(m_axis_tdata),  64'hA5);
        m_axis_tready = 1'b1; step(); m_axis_tready = 1'b0;
        chk("a5_done_vld", 64'(m_axis_tvalid), 64'd0);
        chk("a5_done_cnt", 64'(fifo_count),    64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
